// File: rtl/fetch_sequencer.sv
// Program counter, saved-address registers and run/halt sequencing for the 9-bit core.
// Drives the instruction ROM address every cycle and handshakes Start/Done with the host.
module fetch_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned SPC_OFFSET = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            JumpEqual,
  input  logic            JumpNotEqual,
  input  logic            OffsetEn,
  input  logic [1:0]      PCRegSelect,
  input  logic            Equal,
  input  logic            Ack,
  input  logic            MemWait,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] SAVE_OFS = PC_W'(SPC_OFFSET);
  localparam logic [PC_W-1:0] ONE      = PC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DONE} state_t;

  state_t          state;
  logic [PC_W-1:0] pcreg1, pcreg2, pcreg3;
  logic [PC_W-1:0] target, pc_inc, save_val;
  logic            jump_take, save_en;

  // Both strobes high satisfies one of the two conditions, so it is unconditional.
  always_comb begin
    target = '0;
    case (PCRegSelect)
      2'b01:   target = pcreg1;
      2'b10:   target = pcreg2;
      2'b11:   target = pcreg3;
      default: target = '0;
    endcase
    jump_take = (PCRegSelect != 2'b00) &&
                ((JumpEqual && Equal) || (JumpNotEqual && !Equal));
    save_en   = (PCRegSelect != 2'b00) && !JumpEqual && !JumpNotEqual;
    pc_inc    = ProgCtr + ONE;
    save_val  = ProgCtr + (OffsetEn ? SAVE_OFS : ONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      ProgCtr <= START_PC;
      pcreg1  <= '0;
      pcreg2  <= '0;
      pcreg3  <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state   <= S_RUN;
            ProgCtr <= START_PC;
            Running <= 1'b1;
          end
        end
        S_RUN: begin
          if (MemWait) begin
            state <= S_STALL;
          end else if (Ack) begin
            state   <= S_DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (jump_take) begin
            ProgCtr <= target;
          end else begin
            if (save_en) begin
              case (PCRegSelect)
                2'b01:   pcreg1 <= save_val;
                2'b10:   pcreg2 <= save_val;
                default: pcreg3 <= save_val;
              endcase
            end
            ProgCtr <= pc_inc;
          end
        end
        S_STALL: begin
          if (!MemWait) state <= S_RUN;
        end
        S_DONE: begin
          if (Start) begin
            state   <= S_RUN;
            ProgCtr <= START_PC;
            Running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a 10-bit instance for the main run and
// a 4-bit instance for wrap-around.
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0, JumpEqual = 1'b0, JumpNotEqual = 1'b0, OffsetEn = 1'b0;
  logic [1:0] PCRegSelect = 2'b00;
  logic       Equal = 1'b0, Ack = 1'b0, MemWait = 1'b0;
  logic [9:0] pc_a;
  logic [3:0] pc_b;
  logic       run_a, done_a, run_b, done_b;

  always #5 Clk = ~Clk;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
    .JumpNotEqual(JumpNotEqual), .OffsetEn(OffsetEn), .PCRegSelect(PCRegSelect),
    .Equal(Equal), .Ack(Ack), .MemWait(MemWait),
    .ProgCtr(pc_a), .Running(run_a), .Done(done_a)
  );

  fetch_sequencer #(.PC_W(4)) dut_w4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
    .JumpNotEqual(JumpNotEqual), .OffsetEn(OffsetEn), .PCRegSelect(PCRegSelect),
    .Equal(Equal), .Ack(Ack), .MemWait(MemWait),
    .ProgCtr(pc_b), .Running(run_b), .Done(done_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic        run;
    logic        done;
  } exp_t;

  exp_t        sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m_state, m_pc, m_mask;
  int unsigned m_reg[4];
  bit          chk_small = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] cur_pc();
    return chk_small ? 32'(pc_b) : 32'(pc_a);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endtask

  task automatic step(input logic st, input logic je, input logic jne, input logic off,
                      input logic [1:0] sel, input logic eq, input logic ack, input logic mw);
    exp_t e;
    Start = st; JumpEqual = je; JumpNotEqual = jne; OffsetEn = off;
    PCRegSelect = sel; Equal = eq; Ack = ack; MemWait = mw;
    case (m_state)
      0: if (st) begin m_state = 1; m_pc = 0; end
      1: begin
        if (mw) m_state = 2;
        else if (ack) m_state = 3;
        else if (sel != 2'b00 && ((je && eq) || (jne && !eq) || (je && jne)))
          m_pc = m_reg[sel];
        else begin
          if (sel != 2'b00 && !je && !jne)
            m_reg[sel] = (m_pc + (off ? 2 : 1)) & m_mask;
          m_pc = (m_pc + 1) & m_mask;
        end
      end
      2: if (!mw) m_state = 1;
      default: if (st) begin m_state = 1; m_pc = 0; end
    endcase
    e.pc   = m_pc;
    e.run  = (m_state == 1) || (m_state == 2);
    e.done = (m_state == 3);
    sbq.push_back(e);
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    check("pc", cur_pc(), e.pc);
    check("running", chk_small ? run_b : run_a, e.run);
    check("done", chk_small ? done_b : done_a, e.done);
  endtask

  task automatic nop(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Start = 0; JumpEqual = 0; JumpNotEqual = 0; OffsetEn = 0;
    PCRegSelect = 2'b00; Equal = 0; Ack = 0; MemWait = 0;
    @(posedge Clk);
    #1;
    check("rst_pc_a", 32'(pc_a), 0);
    check("rst_pc_b", 32'(pc_b), 0);
    check("rst_running", run_a, 0);
    check("rst_done", done_a, 0);
    Reset = 1'b1;
    model_reset();
  endtask

  initial begin
    m_mask = 32'h3ff;
    model_reset();
    do_reset();

    step(1, 0, 0, 0, 2'b00, 0, 0, 0);            // start -> 0
    nop(3);                                        // 1,2,3
    check("seq_pc3", 32'(pc_a), 3);
    step(0, 0, 0, 1, 2'b01, 0, 0, 0);            // spc reg1 = 3+2 = 5
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 2'b01, 0, 0, 1);
    check("stall_hold", 32'(pc_a), 4);
    step(0, 0, 1, 0, 2'b01, 0, 0, 0);            // STALL -> RUN
    step(0, 0, 1, 0, 2'b01, 0, 0, 0);            // jne taken after stall
    check("stall_jump", 32'(pc_a), 5);
    step(0, 0, 0, 0, 2'b10, 0, 0, 0);            // spc reg2 = 6
    nop(1);                                        // 7
    step(0, 0, 1, 0, 2'b01, 0, 0, 0);            // jne -> 5
    check("jne_taken", 32'(pc_a), 5);
    nop(2);                                        // 6,7
    step(0, 0, 1, 0, 2'b00, 0, 0, 0);            // sel 00 -> 8
    check("jne_sel0", 32'(pc_a), 8);
    nop(1);                                        // 9
    step(0, 1, 0, 0, 2'b10, 1, 0, 0);            // je -> 6
    check("je_taken", 32'(pc_a), 6);
    nop(3);                                        // 7,8,9
    step(0, 1, 0, 0, 2'b10, 0, 0, 0);            // je not taken -> 10
    check("je_not", 32'(pc_a), 10);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);            // Start ignored in RUN -> 11
    nop(1);                                        // 12
    step(0, 0, 0, 0, 2'b00, 0, 1, 0);            // halt
    check("halt_pc", 32'(pc_a), 12);
    check("halt_done", done_a, 1);
    nop(1);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);            // restart -> 0
    check("restart_pc", 32'(pc_a), 0);
    nop(2);                                        // 1,2
    step(0, 1, 0, 0, 2'b10, 1, 0, 0);            // reg2 kept -> 6
    check("reg2_kept", 32'(pc_a), 6);
    step(0, 0, 1, 0, 2'b01, 0, 0, 0);            // reg1 kept -> 5
    step(0, 1, 1, 0, 2'b10, 0, 0, 0);            // both strobes -> unconditional 6
    check("both_strobes", 32'(pc_a), 6);

    // asynchronous reset between clock edges
    #2;
    Reset = 1'b0;
    #1;
    check("async_pc", 32'(pc_a), 0);
    check("async_running", run_a, 0);
    check("async_done", done_a, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    model_reset();

    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(7) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(15) == 0),
           ($urandom_range(3) == 0));

    chk_small = 1'b1;
    m_mask    = 32'hf;
    do_reset();
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    nop(14);
    check("wrap_14", 32'(pc_b), 14);
    nop(1);
    check("wrap_15", 32'(pc_b), 15);
    step(0, 0, 0, 1, 2'b11, 0, 0, 0);            // reg3 = 15+2 mod 16 = 1
    check("wrap_0", 32'(pc_b), 0);
    step(0, 1, 0, 0, 2'b11, 1, 0, 0);
    check("wrap_saved", 32'(pc_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview: Program-counter and fetch sequencer for the 9-bit core. It holds the program counter, the three saved-address registers (PCreg1..PCreg3) written by spc and targeted by je/jne, and the run/halt handshake with the testbench (Start/Done). It consumes the decoder's jump/save/halt strobes and the ALU equality flag, and drives the instruction ROM address every cycle.

Parameters:
PC_W, 10, program counter and saved-register width in bits.
START_ADDR, 0, PC value loaded on each Start.
SPC_OFFSET, 2, increment applied to the saved address when OffsetEn=1.

Ports:
Clk  in  1  core clock, all state updates on rising edge.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  begin program run; sampled in IDLE and DONE only.
JumpEqual  in  1  decoded je strobe.
JumpNotEqual  in  1  decoded jne strobe.
OffsetEn  in  1  spc saves PC+SPC_OFFSET instead of PC+1.
PCRegSelect  in  2  00 none, 01/10/11 selects PCreg1/2/3.
Equal  in  1  ALU equality flag for the current instruction.
Ack  in  1  decoded halt instruction (all-ones opcode).
MemWait  in  1  data memory not ready; freezes fetch.
ProgCtr  out  PC_W  instruction ROM address.
Running  out  1  high in RUN and STALL.
Done  out  1  high in DONE until next Start.

Behaviour:
- Reset (Reset=0, async): state=IDLE, ProgCtr=START_ADDR, PCreg1..3=0, Running=0, Done=0. Reset mid-run aborts immediately; no pending update survives.
- States: IDLE, RUN, STALL, DONE. Running and Done are registered decodes of the state.
- IDLE: Start=1 -> RUN, ProgCtr<=START_ADDR. Otherwise hold.
- RUN, priority per cycle, highest first:
  1. MemWait=1 -> STALL. ProgCtr and PCregs hold, and all strobes are ignored this cycle.
  2. Ack=1 -> DONE. ProgCtr holds at the halt address.
  3. Jump taken -> ProgCtr<=PCreg[PCRegSelect]. A jump is taken when PCRegSelect!=00 and either (JumpEqual and Equal) or (JumpNotEqual and !Equal).
  4. Save (spc) -> PCreg[PCRegSelect]<=ProgCtr+(OffsetEn?SPC_OFFSET:1), and ProgCtr<=ProgCtr+1. Save applies when PCRegSelect!=00 and JumpEqual=JumpNotEqual=0.
  5. Otherwise ProgCtr<=ProgCtr+1.
- Jump not taken (condition false, or PCRegSelect=00) -> ProgCtr+1; no PCreg write.
- JumpEqual and JumpNotEqual both high: illegal; treat as unconditional jump to the selected register.
- STALL: stays while MemWait=1, with no state change. On MemWait=0 -> RUN; the held instruction is re-evaluated in the next RUN cycle.
- DONE: Done=1 and ProgCtr holds. Start=1 -> RUN, ProgCtr<=START_ADDR, Done<=0. PCregs retain their values across runs; only reset clears them.
- Start in RUN or STALL is ignored.
- Arithmetic is modulo 2^PC_W: increment and save-offset wrap, e.g. (2^PC_W-1)+1=0.
- Jump latency: the target appears on ProgCtr one cycle after the strobe.
- Save/read same register in the same cycle cannot occur (a jump and a save are mutually exclusive by decode). The PCreg write is visible to a jump in the following cycle.

Test Plan:
- Reset then Start: ProgCtr 0,1,2,3 on successive cycles; Running=1, Done=0. Assert Reset low mid-run -> ProgCtr=0, IDLE immediately (asynchronous).
- Save/jump: at PC=5 apply PCRegSelect=10, OffsetEn=0 -> PCreg2=6. At PC=9 apply JumpEqual with Equal=1 and sel=10 -> next ProgCtr=6. Repeat with Equal=0 -> ProgCtr=10.
- jne and offset: at PC=3, spc sel=01 with OffsetEn=1 -> PCreg1=5. At PC=7, JumpNotEqual with Equal=0 and sel=01 -> ProgCtr=5. Same with sel=00 -> ProgCtr=8.
- Stall: MemWait high 3 cycles at PC=4 with a jump strobe present -> PC stays 4 for 3 cycles, then the jump is taken on the first RUN cycle.
- Halt/restart: Ack at PC=12 -> Done=1 next cycle, PC holds 12, Start ignored while running. Start in DONE -> PC=0, Done=0, PCregs unchanged.
- Wrap: PC_W=4. Run from 0 -> sequence 14,15,0. spc at PC=15 with OffsetEn=1 -> PCreg=1.
